// File: rtl/store_queue_pkg.sv
// Shared types and sizing for the store queue.
//   SQ_SIZE / SQ_IDX_W : entry count and index width
//   sq_ptr_t           : entry pointer with one extra wrap bit
//   sq_entry_t         : one store entry {addr_valid, addr, data, usebytes}
//   load_sq_packet_t   : load lookup request {addr, tail_pos}
//   sq_load_packet_t   : load lookup response {stall, usebytes, data}
package store_queue_pkg;

  localparam int SQ_SIZE  = 8;
  localparam int SQ_IDX_W = $clog2(SQ_SIZE);
  localparam int SQ_PTR_W = SQ_IDX_W + 1;

  typedef logic [SQ_PTR_W-1:0] sq_ptr_t;
  typedef logic [SQ_IDX_W-1:0] sq_idx_t;

  typedef struct packed {
    logic        addr_valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  usebytes;
  } sq_entry_t;

  typedef struct packed {
    logic [31:0] addr;
    sq_ptr_t     tail_pos;
  } load_sq_packet_t;

  typedef struct packed {
    logic        stall;
    logic [3:0]  usebytes;
    logic [31:0] data;
  } sq_load_packet_t;

  localparam sq_ptr_t SQ_PTR_ONE = sq_ptr_t'(1);

endpackage

// File: rtl/store_queue_fwd_search.sv
// Combinational store-to-load forwarding search.
//   i_entries : all store queue entries
//   i_head    : oldest live entry pointer (with wrap bit)
//   i_req     : load address and the tail pointer captured at load dispatch
//   o_resp    : stall if any older store address is unknown, else per-byte
//               data from the youngest older store matching the address
module sq_forward_search
  import store_queue_pkg::*;
(
  input  sq_entry_t [SQ_SIZE-1:0] i_entries,
  input  sq_ptr_t                 i_head,
  input  load_sq_packet_t         i_req,
  output sq_load_packet_t         o_resp
);

  sq_ptr_t     w_n;
  sq_idx_t     w_slot;
  logic        w_stall;
  logic [3:0]  w_use;
  logic [31:0] w_data;

  always_comb begin
    w_stall = 1'b0;
    w_use   = '0;
    w_data  = '0;
    w_slot  = '0;
    w_n     = i_req.tail_pos - i_head;
    // A load tail behind head means everything older already drained.
    if (w_n > sq_ptr_t'(SQ_SIZE)) w_n = '0;
    // Walk oldest to youngest so younger matches overwrite older bytes.
    for (int k = 0; k < SQ_SIZE; k++) begin
      w_slot = i_head[SQ_IDX_W-1:0] + sq_idx_t'(k);
      if (sq_ptr_t'(k) < w_n) begin
        if (!i_entries[w_slot].addr_valid) begin
          w_stall = 1'b1;
        end else if (i_entries[w_slot].addr == i_req.addr) begin
          for (int b = 0; b < 4; b++) begin
            if (i_entries[w_slot].usebytes[b]) begin
              w_use[b]         = 1'b1;
              w_data[8*b +: 8] = i_entries[w_slot].data[8*b +: 8];
            end
          end
        end
      end
    end
    o_resp.stall    = w_stall;
    o_resp.usebytes = w_stall ? 4'b0 : w_use;
    o_resp.data     = w_stall ? 32'b0 : w_data;
  end

endmodule

// File: rtl/store_queue.sv
// Circular store queue: allocation at dispatch, fill at execute, in-order
// commit and drain to the data cache, and store-to-load forwarding.
//   clock, reset             : clock, synchronous active-high reset
//   dp_en / dp_tail / sq_full: dispatch allocate, tail pointer, full flag
//   st_exe_*                 : store FU result written into an entry
//   rt_en, squash            : ROB commit, discard of uncommitted entries
//   dc_wr_* / dc_wr_ack      : head-entry write request and its accept
//   ld_addr, ld_tail         : load lookup request
//   ld_stall/usebytes/data   : load lookup response
module store_queue
  import store_queue_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                dp_en,
  output logic [SQ_IDX_W:0]   dp_tail,
  output logic                sq_full,
  input  logic                st_exe_valid,
  input  logic [SQ_IDX_W-1:0] st_exe_idx,
  input  logic [31:0]         st_exe_addr,
  input  logic [31:0]         st_exe_data,
  input  logic [3:0]          st_exe_usebytes,
  input  logic                rt_en,
  input  logic                squash,
  output logic                dc_wr_en,
  output logic [31:0]         dc_wr_addr,
  output logic [31:0]         dc_wr_data,
  output logic [3:0]          dc_wr_mask,
  input  logic                dc_wr_ack,
  input  logic [31:0]         ld_addr,
  input  logic [SQ_IDX_W:0]   ld_tail,
  output logic                ld_stall,
  output logic [3:0]          ld_usebytes,
  output logic [31:0]         ld_data
);

  sq_ptr_t                 r_head;
  sq_ptr_t                 r_cmt;
  sq_ptr_t                 r_tail;
  sq_entry_t [SQ_SIZE-1:0] r_entries;

  sq_entry_t       w_head_entry;
  logic            w_commit;
  logic            w_dispatch;
  logic            w_exe_ok;
  sq_ptr_t         w_cmt_next;
  sq_ptr_t         w_exe_off;
  load_sq_packet_t w_ld_req;
  sq_load_packet_t w_ld_resp;

  assign dp_tail      = r_tail;
  assign sq_full      = (r_tail - r_head) == sq_ptr_t'(SQ_SIZE);
  assign w_head_entry = r_entries[r_head[SQ_IDX_W-1:0]];

  assign dc_wr_en   = (r_head != r_cmt) && w_head_entry.addr_valid;
  assign dc_wr_addr = w_head_entry.addr;
  assign dc_wr_data = w_head_entry.data;
  assign dc_wr_mask = w_head_entry.usebytes;

  assign w_commit   = rt_en && (r_cmt != r_tail);
  assign w_cmt_next = w_commit ? r_cmt + SQ_PTR_ONE : r_cmt;
  assign w_dispatch = dp_en && !sq_full && !squash;

  // Distance of the execute index past cmt, modulo the ring; it is live
  // only while that distance is inside the uncommitted span.
  assign w_exe_off = {1'b0, st_exe_idx - r_cmt[SQ_IDX_W-1:0]};
  assign w_exe_ok  = st_exe_valid && (w_exe_off < (r_tail - r_cmt));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head    <= '0;
      r_cmt     <= '0;
      r_tail    <= '0;
      r_entries <= '0;
    end else begin
      r_cmt <= w_cmt_next;
      if (dc_wr_en && dc_wr_ack) r_head <= r_head + SQ_PTR_ONE;
      if (squash)          r_tail <= w_cmt_next;
      else if (w_dispatch) r_tail <= r_tail + SQ_PTR_ONE;
      // The dispatch slot sits at tail, outside [cmt,tail), so it never
      // collides with an execute write in the same cycle.
      if (w_dispatch) r_entries[r_tail[SQ_IDX_W-1:0]].addr_valid <= 1'b0;
      if (w_exe_ok) begin
        r_entries[st_exe_idx] <= sq_entry_t'{addr_valid: 1'b1,
                                             addr:       st_exe_addr,
                                             data:       st_exe_data,
                                             usebytes:   st_exe_usebytes};
      end
    end
  end

  assign w_ld_req = '{addr: ld_addr, tail_pos: ld_tail};

  sq_forward_search u_fwd (
    .i_entries (r_entries),
    .i_head    (r_head),
    .i_req     (w_ld_req),
    .o_resp    (w_ld_resp)
  );

  assign ld_stall    = w_ld_resp.stall;
  assign ld_usebytes = w_ld_resp.usebytes;
  assign ld_data     = w_ld_resp.data;

endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
- Circular store queue between dispatch, the store FU, the ROB commit path and the data cache.
- Allocates one entry per dispatched store and captures the word address, aligned data and byte mask when the store executes.
- Drains committed stores to the data cache in order.
- Answers the load FU's one-cycle lookup with a stall flag, or with byte-forwarded data from older stores.

Parameters:
- SQ_SIZE, 8, number of entries (power of 2).
- SQ_IDX_W, $clog2(SQ_SIZE), entry index width. Pointers carry one extra wrap bit (SQ_IDX_W+1).

Ports:
- clock  in  1  system clock
- reset  in  1  reset reset, synchronous, active-high; clock clock
- dp_en  in  1  allocate one entry at tail this cycle
- dp_tail  out  SQ_IDX_W+1  current tail pointer with wrap bit. A store keeps the low bits as its entry index; a load keeps the full value as its lookup tail_pos.
- sq_full  out  1  count==SQ_SIZE
- st_exe_valid  in  1  store FU result valid
- st_exe_idx  in  SQ_IDX_W  entry being filled
- st_exe_addr  in  32  word-aligned address (bits[1:0]=0)
- st_exe_data  in  32  byte-lane-aligned data
- st_exe_usebytes  in  4  byte mask
- rt_en  in  1  ROB commits the oldest uncommitted store
- squash  in  1  discard all uncommitted entries
- dc_wr_en  out  1  write request for head entry
- dc_wr_addr  out  32  head address
- dc_wr_data  out  32  head data
- dc_wr_mask  out  4  head byte mask
- dc_wr_ack  in  1  cache accepted write
- ld_addr  in  32  load word address
- ld_tail  in  SQ_IDX_W+1  load's captured tail pointer
- ld_stall  out  1  older store address unknown
- ld_usebytes  out  4  bytes forwarded
- ld_data  out  32  forwarded bytes in lane position; non-forwarded lanes 0

Behaviour:
- State: pointers head, cmt, tail (SQ_IDX_W+1 bits each); entry array {addr_valid, addr, data, usebytes}.
- Invariants: head ≤ cmt ≤ tail in modular order. count = tail−head (mod 2^(SQ_IDX_W+1)).
- Reset: all pointers 0, all addr_valid 0. Outputs: dp_tail=0, sq_full=0, dc_wr_en=0, ld_stall=0, ld_usebytes=0, ld_data=0.
- Dispatch: on dp_en && !sq_full, entry[tail].addr_valid<=0 and tail<=tail+1. dp_en while full is ignored; the bench flags it as an error.
- Execute: on st_exe_valid, write addr/data/usebytes into entry[st_exe_idx] and set addr_valid<=1. The write is ignored if the index is not in [cmt,tail).
- Commit: on rt_en && cmt!=tail, cmt<=cmt+1. rt_en when cmt==tail is ignored.
- Drain, request side: dc_wr_en = (head!=cmt) && entry[head].addr_valid. dc_wr_* are combinational from entry[head] and stay stable until the ack.
- Drain, ack side: on dc_wr_ack with dc_wr_en, head<=head+1. Ack without dc_wr_en is ignored.
- Squash: tail<=cmt after this cycle's commit, so squash and rt_en together means tail<=cmt+1. Squash also overrides a same-cycle dp_en. It does not touch head or cmt, and the drain continues.
- Load lookup timing: purely combinational from registered state. A same-cycle st_exe write is not visible to the lookup until the next cycle.
- Load lookup, older range: pointers p with head ≤ p < ld_tail, i.e. n = ld_tail−head entries. n=0 means no older stores.
- Load lookup, stall: if any older entry has addr_valid=0, then ld_stall=1, ld_usebytes=0 and ld_data=0.
- Load lookup, forwarding: otherwise ld_stall=0, and for each byte i the youngest older entry with addr==ld_addr and usebytes[i]=1 supplies ld_data[8i+:8] and sets ld_usebytes[i].
- Load lookup, wrap: older entries that have already drained are absent from the range. A full queue (n=SQ_SIZE) is distinguished from empty by the wrap bit.
- Simultaneous events: dispatch, execute, commit, drain and lookup may all occur in one cycle without interference. A dispatch that reuses a slot freed by a same-cycle drain is legal only when it is not full before the drain; sq_full is the pre-update value.

Decomposition:
- Shared package: SQ_SIZE, SQ_IDX_W, SQ_ENTRY struct {addr_valid, addr[31:0], data[31:0], usebytes[3:0]}, LOAD_SQ_PACKET {addr, tail_pos}, SQ_LOAD_PACKET {stall, usebytes, data}.
- Sub-module sq_forward_search: combinational age-ordered per-byte priority search over the older range, producing stall, usebytes and data. The top level holds the pointers and entry regs.

Test Plan:
- Reset, then dispatch 8 stores with no execute: sq_full=1 and dp_tail=8 (wrap bit set). A load with ld_tail=8 gets ld_stall=1.
- Store idx0 addr 0x100 data 0x11223344 mask 1111; store idx1 addr 0x100 data 0xAA000000 mask 1000. Load addr 0x100, ld_tail=2: ld_stall=0, usebytes=1111, data=0xAA223344.
- Same entries, load ld_tail=1: data=0x11223344. Load ld_tail=0: usebytes=0000, stall=0.
- Store idx0 executed, idx1 not. Load with ld_tail=2: stall=1. Load with ld_tail=1: stall=0.
- Commit idx0 with dc_wr_ack held low for 3 cycles: dc_wr_en=1 and outputs stable. Ack: head advances, and a load addr 0x100 with the old ld_tail no longer sees idx0.
- Dispatch 4, commit 1, then squash with rt_en in the same cycle: tail=cmt=2. Next dispatch returns dp_tail=2, and the drain of idx0 still completes.
